// File: rtl/exc_pkg.sv
// Shared constants for the MEM-stage exception controller: exception codes,
// mem_flags bit positions, controller states and the default exception vector.
package exc_pkg;

  // Exception codes driven on cp0_exctype
  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;
  localparam logic [4:0] EXC_ERET = 5'h0e;

  // Bit positions inside mem_flags
  localparam int FLG_ADEL_IF = 0;
  localparam int FLG_RI      = 1;
  localparam int FLG_OV      = 2;
  localparam int FLG_SYS     = 3;
  localparam int FLG_BP      = 4;
  localparam int FLG_ERET    = 5;
  localparam int FLG_ADEL_LD = 6;
  localparam int FLG_ADES    = 7;

  // Controller states
  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    REDIRECT = 1'b1
  } exc_state_e;

  // Target PC for every exception other than ERET
  localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

endpackage

// File: rtl/exc_ctrl_if.sv
// MEM-stage / CP0 / fetch signals seen by the exception controller.
// master = the controller, slave = the surrounding pipeline and CP0.
interface exc_ctrl_if;
  import exc_pkg::*;

  // MEM-stage instruction information
  logic        mem_valid;
  logic [31:0] mem_pc;
  logic        mem_indelayslot;
  logic [7:0]  mem_flags;
  logic [31:0] mem_addr;

  // Raw asynchronous interrupt lines IP7..IP2
  logic [5:0]  ext_int;

  // Current CP0 register values
  logic [31:0] cp0_status;
  logic [31:0] cp0_cause;
  logic [31:0] cp0_epc;

  // Fetch front end handshake
  logic        fetch_ready;

  // Commit strobe towards CP0
  logic        cp0_en;
  logic [4:0]  cp0_exctype;
  logic [31:0] cp0_pc;
  logic [31:0] cp0_badvaddr;
  logic        cp0_indelayslot;

  // Pipeline control
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  modport master (
    input  mem_valid, mem_pc, mem_indelayslot, mem_flags, mem_addr,
    input  ext_int, cp0_status, cp0_cause, cp0_epc, fetch_ready,
    output cp0_en, cp0_exctype, cp0_pc, cp0_badvaddr, cp0_indelayslot,
    output flush, redirect_valid, redirect_pc, busy
  );

  modport slave (
    output mem_valid, mem_pc, mem_indelayslot, mem_flags, mem_addr,
    output ext_int, cp0_status, cp0_cause, cp0_epc, fetch_ready,
    input  cp0_en, cp0_exctype, cp0_pc, cp0_badvaddr, cp0_indelayslot,
    input  flush, redirect_valid, redirect_pc, busy
  );

endinterface

// File: rtl/int_sync.sv
// Multi-flop synchroniser for the asynchronous hardware interrupt lines.
// Output lags the input by STAGES clock edges; all flops clear on rst.
module int_sync #(
  parameter int WIDTH  = 6,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [STAGES-1:0][WIDTH-1:0] stage_r;

  // Shift the raw lines through the synchroniser chain
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_r <= '0;
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[STAGES-1];

endmodule

// File: rtl/exc_ctrl.sv
// MEM-stage exception controller: detects the highest-priority exception or
// interrupt, issues a single-cycle commit strobe to CP0, flushes the pipe and
// holds the redirect PC until the fetch front end accepts it.
module exc_ctrl
  import exc_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR  = EXC_VECTOR_DEFAULT,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  exc_ctrl_if.master  bus
);

  localparam logic [0:0] ST_IDLE     = IDLE;
  localparam logic [0:0] ST_REDIRECT = REDIRECT;

  logic [0:0]  state_r;
  logic [31:0] redirect_pc_r;
  logic [5:0]  sync_int;

  logic [7:0]  ip_vec;
  logic        int_pending;
  logic        detect_en;
  logic        any_exc;
  logic        hit;
  logic [4:0]  exc_code;
  logic [31:0] exc_badvaddr;
  logic        exc_is_eret;
  logic [31:0] exc_target;

  int_sync #(
    .WIDTH  (6),
    .STAGES (SYNC_STAGES)
  ) u_int_sync (
    .clk  (clk),
    .rst  (rst),
    .din  (bus.ext_int),
    .dout (sync_int)
  );

  // Pending-interrupt evaluation: software bits IP1..IP0 from Cause, hardware
  // bits IP7..IP2 from the synchroniser, masked by Status.IM and gated by IE/EXL
  always_comb begin
    ip_vec      = {sync_int, bus.cp0_cause[9:8]} & bus.cp0_status[15:8];
    int_pending = bus.cp0_status[0] & ~bus.cp0_status[1] & (|ip_vec);
    detect_en   = (state_r == ST_IDLE) & bus.mem_valid & ~rst;
  end

  // Priority encoder selecting exception code, bad address and ERET marker
  always_comb begin
    any_exc      = 1'b1;
    exc_code     = 5'h00;
    exc_badvaddr = 32'h0000_0000;
    exc_is_eret  = 1'b0;
    if (int_pending) begin
      exc_code = EXC_INT;
    end else if (bus.mem_flags[FLG_ADEL_IF]) begin
      exc_code     = EXC_ADEL;
      exc_badvaddr = bus.mem_pc;
    end else if (bus.mem_flags[FLG_RI]) begin
      exc_code = EXC_RI;
    end else if (bus.mem_flags[FLG_OV]) begin
      exc_code = EXC_OV;
    end else if (bus.mem_flags[FLG_SYS]) begin
      exc_code = EXC_SYS;
    end else if (bus.mem_flags[FLG_BP]) begin
      exc_code = EXC_BP;
    end else if (bus.mem_flags[FLG_ERET]) begin
      exc_code    = EXC_ERET;
      exc_is_eret = 1'b1;
    end else if (bus.mem_flags[FLG_ADEL_LD]) begin
      exc_code     = EXC_ADEL;
      exc_badvaddr = bus.mem_addr;
    end else if (bus.mem_flags[FLG_ADES]) begin
      exc_code     = EXC_ADES;
      exc_badvaddr = bus.mem_addr;
    end else begin
      any_exc = 1'b0;
    end
  end

  // Commit decision and redirect target; EPC is taken in the detect cycle
  always_comb begin
    hit        = detect_en & any_exc;
    exc_target = exc_is_eret ? bus.cp0_epc : EXC_VECTOR;
  end

  // Outputs: the CP0 strobe is combinational so CP0 can capture mid-cycle
  always_comb begin
    bus.cp0_en          = hit;
    bus.cp0_exctype     = hit ? exc_code : 5'h00;
    bus.cp0_pc          = hit ? bus.mem_pc : 32'h0000_0000;
    bus.cp0_badvaddr    = hit ? exc_badvaddr : 32'h0000_0000;
    bus.cp0_indelayslot = hit & bus.mem_indelayslot;
    bus.flush           = hit | (state_r == ST_REDIRECT);
    bus.redirect_valid  = (state_r == ST_REDIRECT);
    bus.redirect_pc     = redirect_pc_r;
    bus.busy            = (state_r != ST_IDLE);
  end

  // FSM: hold the redirect until the front end accepts the new PC
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      redirect_pc_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hit) begin
            state_r       <= ST_REDIRECT;
            redirect_pc_r <= exc_target;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_REDIRECT: begin
          if (bus.fetch_ready) begin
            state_r <= ST_IDLE;
          end else begin
            state_r <= ST_REDIRECT;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/exc_ctrl.md
# exc_ctrl

Exception detection, prioritisation and redirect controller for the MEM stage of the 5-stage MIPS core. It collects per-instruction exception flags and external interrupts, and drives the CP0 register block's exception strobe (en / exctype / pc / indelayslot / badvaddr). It then flushes the pipeline and holds a redirect PC (exception vector or EPC) until the AXI fetch front end can accept it. It consumes CP0 Status/Cause/EPC, so it is the producer side of the CP0 exception interface.

## Interface
- EXC_VECTOR, 32'hBFC0_0380, target PC for every exception except ERET
- SYNC_STAGES, 2, flop depth of the external-interrupt synchroniser
- clk  in  1  core clock; all state updates on posedge
- rst  in  1  reset, synchronous, active-high
- mem_valid  in  1  MEM stage holds a real (non-bubble) instruction
- mem_pc  in  32  PC of the MEM instruction
- mem_indelayslot  in  1  MEM instruction is in a branch delay slot
- mem_flags  in  8  bit0 ADEL_IF, bit1 RI, bit2 OV, bit3 SYS, bit4 BP, bit5 ERET, bit6 ADEL_LD, bit7 ADES
- mem_addr  in  32  load/store effective address
- ext_int  in  6  asynchronous hardware interrupt lines (IP7..IP2)
- cp0_status, cp0_cause, cp0_epc  in  32 each  current CP0 register values
- fetch_ready  in  1  front end has drained outstanding AXI reads and accepts a new PC
- cp0_en  out  1  exception/ERET commit strobe to CP0
- cp0_exctype  out  5  exception code
- cp0_pc, cp0_badvaddr  out  32  faulting PC / bad address
- cp0_indelayslot  out  1  passthrough of mem_indelayslot
- flush  out  1  kill IF..MEM and block writeback of the MEM instruction
- redirect_valid  out  1  redirect_pc is valid
- redirect_pc  out  32  new fetch PC
- busy  out  1  controller not IDLE (stall hazard unit)

## Operation
- int_pending = Status[0] & ~Status[1] & |((Cause[9:8] | {sync_int,2'b0}[15:8] mapped to IP7..IP2) & Status[15:8]); sync_int is the synchroniser output.
- Detection only in IDLE with mem_valid=1. Priority, highest first: INT, ADEL_IF, RI, OV, SYS, BP, ERET, ADEL_LD, ADES.
- Codes (exc_pkg): INT 5'h00, ADEL 5'h04, ADES 5'h05, SYS 5'h08, BP 5'h09, RI 5'h0a, OV 5'h0c, ERET 5'h0e.
- Badvaddr: ADEL_IF -> mem_pc; ADEL_LD/ADES -> mem_addr; all others 0.
- Redirect target: ERET -> cp0_epc sampled in the detect cycle; all others -> EXC_VECTOR.
- FSM: IDLE -> (hit) REDIRECT -> (fetch_ready) IDLE. In REDIRECT: redirect_valid=1, flush=1, busy=1, cp0_en=0, all new flags and interrupts ignored.

## Timing
- Detect cycle D: cp0_en, cp0_exctype, cp0_pc, cp0_badvaddr, cp0_indelayslot and flush are combinational in D, so CP0 captures the commit on the negedge inside D.
- cp0_en is high for exactly one cycle per event.
- redirect_pc is registered at the posedge ending D. redirect_valid rises in D+1 and stays high through the first cycle with fetch_ready=1, inclusive. State returns to IDLE at that posedge.
- Minimum redirect is 1 cycle (fetch_ready=1 in D+1). There is no upper bound. redirect_pc is stable while redirect_valid=1.
- ext_int to int_pending latency is SYNC_STAGES cycles.
- Reset values: state IDLE; synchroniser flops 0; redirect_pc 0; every output 0.
- rst asserted in REDIRECT: IDLE next cycle, and redirect_valid drops at that posedge.
- Multiple flags in the same cycle: only the highest-priority flag commits. No queued second event.
- mem_valid=0 with flags set: no action.

## Structure
- exc_pkg holds: exctype constants, mem_flags bit indices, the state enum {IDLE, REDIRECT}, and the EXC_VECTOR default.
- One sub-module, int_sync: a SYNC_STAGES-deep 6-bit synchroniser, reset to 0.
- Priority encoder, badvaddr mux and FSM stay in exc_ctrl.

## Test plan
- OV at mem_pc=0x8000_1000, mem_indelayslot=0, fetch_ready=1 -> cp0_en=1 for one cycle, exctype 0x0c, cp0_pc 0x8000_1000, flush=1 in D; redirect_valid for 1 cycle with redirect_pc 0xBFC0_0380.
- ADES with mem_addr=0x0000_0003 and RI also set -> exctype 0x0a (RI wins), cp0_badvaddr=0. ADES alone -> exctype 0x05, badvaddr 0x3.
- ERET with cp0_epc=0x8000_2004 and fetch_ready low for 3 cycles -> exctype 0x0e; redirect_valid high 4 cycles, redirect_pc 0x8000_2004, busy high 4 cycles; a SYS flag during the wait is ignored.
- ext_int[0]=1, Status=0x0000_0401 -> cp0_en with exctype 0x00 on the second cycle after assertion. With Status[1]=1, or with Status[0]=0, there is no cp0_en.
- Software interrupt: Cause[8]=1, Status=0x0000_0101 -> INT taken. mem_valid=0 -> no action until a valid instruction reaches MEM.
- rst pulsed in the second cycle of REDIRECT -> redirect_valid=0, busy=0 and all outputs 0 next cycle; a subsequent OV is handled normally.
